// File: rtl/pll_spi_master.sv
// SPI master that programs the PLL enable/trim registers with one start-triggered write frame.
// Optional PLL_SPI_READBACK_EN adds a read frame whose returned data bytes are compared (err).
module pll_spi_master #(
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [7:0]  PLL_ADDR = 8'h08
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       cfg_bias_ena,
  input  logic       cfg_cp_ena,
  input  logic       cfg_vco_ena,
  input  logic [3:0] cfg_trim,
  input  logic       SDO,
  output logic       CSB,
  output logic       SCK,
  output logic       SDI,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [7:0] HP_RELOAD = 8'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP,
`ifdef PLL_SPI_READBACK_EN
    RD_SETUP,
    RD_SHIFT,
    RD_HOLD,
    RD_GAP,
`endif
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  hp_q, hp_d;
  logic [5:0]  bit_q, bit_d;
  logic [31:0] sh_q, sh_d;
  logic        csb_q, csb_d;
  logic        sck_q, sck_d;
  logic        sdi_q, sdi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        hp_zero, in_shift, in_frame;
`ifdef PLL_SPI_READBACK_EN
  logic [15:0] data_q, data_d;
  logic [15:0] rd_q, rd_d;
  logic        err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    csb_d   = csb_q;
    sck_d   = sck_q;
    sdi_d   = sdi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef PLL_SPI_READBACK_EN
    data_d  = data_q;
    rd_d    = rd_q;
    err_d   = err_q;
    in_shift = (state_q == SHIFT) || (state_q == RD_SHIFT);
`else
    in_shift = (state_q == SHIFT);
`endif
    hp_zero  = (hp_q == 8'd0);
    in_frame = (state_q != IDLE) && (state_q != DONE);

    // every timed phase lasts CLK_DIV cycles; reload instead of wrapping
    if (in_frame) hp_d = hp_zero ? HP_RELOAD : hp_q - 8'd1;

    unique case (state_q)
      IDLE: if (start) begin
        state_d = SETUP;
        hp_d    = HP_RELOAD;
        sh_d    = {8'h80, PLL_ADDR, 5'b0, cfg_bias_ena, cfg_cp_ena, cfg_vco_ena, 4'b0, cfg_trim};
        csb_d   = 1'b0;
        sdi_d   = sh_d[31];
        busy_d  = 1'b1;
`ifdef PLL_SPI_READBACK_EN
        data_d  = sh_d[15:0];
        err_d   = 1'b0;
`endif
      end
      SETUP: if (hp_zero) begin
        state_d = SHIFT;
        sck_d   = 1'b1;
        bit_d   = 6'd31;
      end
      SHIFT: if (hp_zero && !sck_q && bit_q == 6'd0) state_d = HOLD;
      HOLD: if (hp_zero) begin
        state_d = GAP;
        csb_d   = 1'b1;
        sdi_d   = 1'b0;
      end
      GAP: if (hp_zero) begin
`ifdef PLL_SPI_READBACK_EN
        state_d = RD_SETUP;
        sh_d    = {8'h40, PLL_ADDR, 16'h0000};
        csb_d   = 1'b0;
        sdi_d   = sh_d[31];
`else
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
`endif
      end
`ifdef PLL_SPI_READBACK_EN
      RD_SETUP: if (hp_zero) begin
        state_d = RD_SHIFT;
        sck_d   = 1'b1;
        bit_d   = 6'd31;
        rd_d    = {rd_q[14:0], SDO};
      end
      RD_SHIFT: if (hp_zero && !sck_q && bit_q == 6'd0) state_d = RD_HOLD;
      RD_HOLD: if (hp_zero) begin
        state_d = RD_GAP;
        csb_d   = 1'b1;
        sdi_d   = 1'b0;
      end
      RD_GAP: if (hp_zero) begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        err_d   = (rd_q != data_q);
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // SDI advances on the falling SCK edge so it is stable across each rising edge
    if (in_shift && hp_zero) begin
      if (sck_q) begin
        sck_d = 1'b0;
        if (bit_q != 6'd0) begin
          sh_d  = {sh_q[30:0], 1'b0};
          sdi_d = sh_q[30];
        end
      end else if (bit_q != 6'd0) begin
        sck_d = 1'b1;
        bit_d = bit_q - 6'd1;
`ifdef PLL_SPI_READBACK_EN
        if (state_q == RD_SHIFT) rd_d = {rd_q[14:0], SDO};
`endif
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      hp_q    <= 8'd0;
      bit_q   <= 6'd0;
      sh_q    <= 32'd0;
      csb_q   <= 1'b1;
      sck_q   <= 1'b0;
      sdi_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      csb_q   <= csb_d;
      sck_q   <= sck_d;
      sdi_q   <= sdi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef PLL_SPI_READBACK_EN
  always_ff @(posedge CLK) begin
    if (!RST) begin
      data_q <= 16'd0;
      rd_q   <= 16'd0;
      err_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      rd_q   <= rd_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_sdo;
  assign unused_sdo = SDO;
  assign err        = 1'b0;
`endif

  assign CSB  = csb_q;
  assign SCK  = sck_q;
  assign SDI  = sdi_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
